// File: rtl/segway_pkg.sv
// Shared constants and types for the balance-controller datapath.
package segway_pkg;

  localparam int SPD_W = 12;

  localparam logic [11:0] STEER_MIN = 12'h200;
  localparam logic [11:0] STEER_MAX = 12'hE00;
  localparam logic [11:0] STEER_MID = 12'h7FF;

  typedef logic signed [SPD_W-1:0] spd_t;

  function automatic logic [11:0] clip_steer(input logic [11:0] pot);
    if (pot < STEER_MIN)      return STEER_MIN;
    else if (pot > STEER_MAX) return STEER_MAX;
    else                      return pot;
  endfunction

endpackage

// File: rtl/sat_signed.sv
// Signed saturator: clamps an IN_W-bit signed value into OUT_W bits.
module sat_signed #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 12
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    if (din > MAX_V)      dout = MAX_V[OUT_W-1:0];
    else if (din < MIN_V) dout = MIN_V[OUT_W-1:0];
    else                  dout = din[OUT_W-1:0];
  end

endmodule

// File: rtl/balance_spd_calc.sv
// Scales the PID word by soft-start, mixes steering, saturates to wheel speeds.
// Optional motor deadzone compensation is built when DEADZONE_COMP_EN is defined.
module balance_spd_calc
  import segway_pkg::*;
#(
  parameter logic [11:0] MIN_DUTY     = 12'd96,
  parameter logic [11:0] TOO_FAST_THR = 12'd1536,
  parameter int          TOO_FAST_CNT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwr_up,
  input  logic               vld_in,
  input  logic signed [11:0] PID_cntrl,
  input  logic        [7:0]  ss_tmr,
  input  logic        [11:0] steer_pot,
  input  logic               en_steer,
  output logic signed [11:0] lft_spd,
  output logic signed [11:0] rght_spd,
  output logic               vld_out,
  output logic               too_fast
);

  localparam logic [3:0] CNT_MAX = 4'(TOO_FAST_CNT);

  logic               v1_q, v2_q;
  spd_t               pid_ss_q, steer_adj_q;
  logic signed [12:0] lft_t_q, rght_t_q;
  logic        [3:0]  cnt_q;

  logic signed [20:0] prod;
  logic signed [12:0] steer_diff;
  spd_t               pid_ss_d, steer_adj_d;
  logic signed [12:0] lft_t_d, rght_t_d;
  logic signed [13:0] lft_sh, rght_sh;
  spd_t               lft_sat, rght_sat;
  logic               over;
  logic        [3:0]  cnt_d;

  function automatic logic signed [13:0] shape(input logic signed [12:0] t);
    logic signed [13:0] te;
    te = 14'(t);
`ifdef DEADZONE_COMP_EN
    if (t > 0)      return te + $signed({2'b00, MIN_DUTY});
    else if (t < 0) return te - $signed({2'b00, MIN_DUTY});
    else            return '0;
`else
    return te;
`endif
  endfunction

  function automatic logic over_thr(input spd_t v);
    logic signed [12:0] v13, thr;
    v13 = 13'(v);
    thr = $signed({1'b0, TOO_FAST_THR});
    return (v13 > thr) || (v13 < -thr);
  endfunction

  // >>> on signed operands floors toward negative infinity, matching the scaling intent
  always_comb begin
    prod        = 21'(PID_cntrl) * 21'($signed({1'b0, ss_tmr}));
    pid_ss_d    = 12'(prod >>> 8);
    steer_diff  = $signed(13'(clip_steer(steer_pot)) - 13'(STEER_MID));
    steer_adj_d = en_steer ? 12'(steer_diff >>> 3) : '0;
    lft_t_d     = 13'(pid_ss_q) + 13'(steer_adj_q);
    rght_t_d    = 13'(pid_ss_q) - 13'(steer_adj_q);
    lft_sh      = shape(lft_t_q);
    rght_sh     = shape(rght_t_q);
  end

  sat_signed #(.IN_W(14), .OUT_W(SPD_W)) u_sat_lft  (.din(lft_sh),  .dout(lft_sat));
  sat_signed #(.IN_W(14), .OUT_W(SPD_W)) u_sat_rght (.din(rght_sh), .dout(rght_sat));

  always_comb begin
    over  = over_thr(lft_sat) || over_thr(rght_sat);
    cnt_d = '0;
    if (over) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      vld_out     <= 1'b0;
      pid_ss_q    <= '0;
      steer_adj_q <= '0;
      lft_t_q     <= '0;
      rght_t_q    <= '0;
      lft_spd     <= '0;
      rght_spd    <= '0;
      cnt_q       <= '0;
      too_fast    <= 1'b0;
    end else if (!pwr_up) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      vld_out     <= 1'b0;
      pid_ss_q    <= '0;
      steer_adj_q <= '0;
      lft_t_q     <= '0;
      rght_t_q    <= '0;
      lft_spd     <= '0;
      rght_spd    <= '0;
      cnt_q       <= '0;
      too_fast    <= 1'b0;
    end else begin
      v1_q    <= vld_in;
      v2_q    <= v1_q;
      vld_out <= v2_q;
      if (vld_in) begin
        pid_ss_q    <= pid_ss_d;
        steer_adj_q <= steer_adj_d;
      end
      if (v1_q) begin
        lft_t_q  <= lft_t_d;
        rght_t_q <= rght_t_d;
      end
      // persistence filter only advances when a new result lands
      if (v2_q) begin
        lft_spd  <= lft_sat;
        rght_spd <= rght_sat;
        cnt_q    <= cnt_d;
        too_fast <= (cnt_d == CNT_MAX);
      end
    end
  end

endmodule

// File: tb/tb_balance_spd_calc.sv
// Directed self-checking bench for balance_spd_calc (expectations adapt to DEADZONE_COMP_EN).
module tb_balance_spd_calc;

`ifdef DEADZONE_COMP_EN
  localparam int DZ = 96;
`else
  localparam int DZ = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n, pwr_up, vld_in, en_steer;
  logic signed [11:0] PID_cntrl;
  logic        [7:0]  ss_tmr;
  logic        [11:0] steer_pot;
  logic signed [11:0] lft_spd, rght_spd;
  logic               vld_out, too_fast;

  int n_chk = 0;
  int n_err = 0;

  balance_spd_calc dut (
    .clk(clk), .rst_n(rst_n), .pwr_up(pwr_up), .vld_in(vld_in),
    .PID_cntrl(PID_cntrl), .ss_tmr(ss_tmr), .steer_pot(steer_pot),
    .en_steer(en_steer), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .vld_out(vld_out), .too_fast(too_fast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic signed [11:0] pid, input logic [7:0] ss,
                       input logic [11:0] st, input logic en);
    PID_cntrl = pid;
    ss_tmr    = ss;
    steer_pot = st;
    en_steer  = en;
  endtask

  task automatic send(input logic signed [11:0] pid, input logic [7:0] ss,
                      input logic [11:0] st, input logic en);
    @(negedge clk);
    drive(pid, ss, st, en);
    vld_in = 1'b1;
    @(negedge clk);
    vld_in = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int l, input int r, input int tf);
    int lat;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (vld_out) begin
        lat = i;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_lft"}, int'(lft_spd), l);
    chk({tag, "_rght"}, int'(rght_spd), r);
    chk({tag, "_tf"}, int'(too_fast), tf);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, int'(vld_out), 0);
  endtask

  task automatic no_vld(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (vld_out) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    pwr_up = 1'b1;
    vld_in = 1'b0;
    drive(12'sd0, 8'h00, 12'h000, 1'b0);
    #12;
    chk("rst_lft", int'(lft_spd), 0);
    chk("rst_rght", int'(rght_spd), 0);
    chk("rst_vld", int'(vld_out), 0);
    chk("rst_tf", int'(too_fast), 0);
    @(negedge clk);
    rst_n = 1'b1;

    send(12'sh100, 8'hFF, 12'h000, 1'b0);
    expect_result("t1", 255 + DZ, 255 + DZ, 0);

    send(12'sh100, 8'hFF, 12'hA00, 1'b1);
    expect_result("t2", 319 + DZ, 191 + DZ, 0);

    send(12'sh7FF, 8'hFF, 12'hFFF, 1'b1);
    expect_result("t3p", 2047, 1847 + DZ, 0);
    send(12'sh800, 8'hFF, 12'h000, 1'b1);
    expect_result("t3n", -2048, -1848 - DZ, 0);

    // flush via pwr_up one edge after the sample enters; also clears the over-speed count
    @(negedge clk);
    drive(12'sh7FF, 8'hFF, 12'hFFF, 1'b1);
    vld_in = 1'b1;
    @(negedge clk);
    vld_in = 1'b0;
    pwr_up = 1'b0;
    @(negedge clk);
    pwr_up = 1'b1;
    no_vld("t6a_novld", 5);
    chk("t6a_lft", int'(lft_spd), 0);
    chk("t6a_rght", int'(rght_spd), 0);
    chk("t6a_tf", int'(too_fast), 0);

    // streaming: six over-speed samples then one quiet sample
    fork
      begin
        for (int n = 0; n < 8; n++) begin
          @(negedge clk);
          if (n < 6)       begin drive(12'sh7FF, 8'hFF, 12'hFFF, 1'b1); vld_in = 1'b1; end
          else if (n == 6) begin drive(12'sh000, 8'hFF, 12'hFFF, 1'b1); vld_in = 1'b1; end
          else             vld_in = 1'b0;
        end
      end
      begin
        int idx;
        idx = 0;
        repeat (14) begin
          @(posedge clk); #1;
          if (vld_out) begin
            if (idx < 6) begin
              chk($sformatf("t4_lft%0d", idx), int'(lft_spd), 2047);
              chk($sformatf("t4_rght%0d", idx), int'(rght_spd), 1847 + DZ);
              chk($sformatf("t4_tf%0d", idx), int'(too_fast), (idx >= 3) ? 1 : 0);
            end else begin
              chk($sformatf("t4_lft%0d", idx), int'(lft_spd), 192 + DZ);
              chk($sformatf("t4_rght%0d", idx), int'(rght_spd), -192 - DZ);
              chk($sformatf("t4_tf%0d", idx), int'(too_fast), 0);
            end
            idx++;
          end
        end
        chk("t4_count", idx, 7);
      end
    join

    send(12'sh7FF, 8'h00, 12'h000, 1'b0);
    expect_result("t5a", 0, 0, 0);
    send(-12'sd1, 8'h01, 12'h000, 1'b0);
    expect_result("t5b", -1 - DZ, -1 - DZ, 0);

    // async reset while a sample is in flight
    @(negedge clk);
    drive(12'sh100, 8'hFF, 12'h000, 1'b0);
    vld_in = 1'b1;
    @(negedge clk);
    vld_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6b_lft", int'(lft_spd), 0);
    chk("t6b_rght", int'(rght_spd), 0);
    chk("t6b_vld", int'(vld_out), 0);
    chk("t6b_tf", int'(too_fast), 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_vld("t6b_novld", 5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
